hazard_tracker: RTL and testbench
=================================

HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 SHALL have parameter NSTAGE, default 3: tracked in-flight stages after D (E, M, W); legal range 2..6.
REQ-002 SHALL have parameter MULT_LAT, default 5: MDU busy cycles for mult/multu; legal range 1..15.
REQ-003 SHALL have parameter DIV_LAT, default 10: MDU busy cycles for div/divu; legal range 1..15.
REQ-004 SHALL have one clock and a synchronous, active-high reset, named as the codebase does: clk, reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 d_valid  in  1  D-stage holds a real instruction; 0 = bubble.
REQ-008 d_a1 / d_a2  in  5 each  D-stage source registers.
REQ-009 d_tuse1 / d_tuse2  in  2 each  cycles until each source is needed, counted from D.
REQ-010 d_a3  in  5  D-stage destination register; 0 = no write.
REQ-011 d_tnew  in  2  cycles until the result exists, counted from D.
REQ-012 d_mdu_req  in  1  D-stage instruction uses the MDU (mult/div/mf*/mt*).
REQ-013 d_mdu_start  in  1  D-stage instruction starts a multi-cycle MDU op.
REQ-014 d_mdu_div  in  1  qualifies d_mdu_start: 1 = div/divu, 0 = mult/multu.
REQ-015 flush  in  1  exception/eret flush of all in-flight slots.
REQ-016 stall  out  1  freeze PC and D; insert a bubble into E.
REQ-017 fwd_sel1 / fwd_sel2  out  3 each  D-stage operand source: 0 = register file, k = slot k-1.
REQ-018 mdu_busy  out  1  MDU cycle counter is nonzero.

Function
REQ-019 SHALL keep NSTAGE slots, slot 0 = E. Each slot holds a3 (5b) and rem (2b).
REQ-020 Every cycle, slot k SHALL move to slot k+1 and rem SHALL decrement, saturating at 0. The content of slot NSTAGE-1 SHALL be dropped.
REQ-021 If d_valid=1, stall=0 and flush=0, slot 0 SHALL load a3=d_a3 and rem=max(d_tnew-1,0). Otherwise slot 0 SHALL load a3=0 and rem=0.
REQ-022 A slot SHALL match source i when its a3 equals d_a_i and d_a_i is not 0. Only the youngest (lowest-index) matching slot SHALL be considered for that source.
REQ-023 Source i SHALL request a stall when d_valid=1 and the youngest matching slot has rem > d_tuse_i.
REQ-024 fwd_sel_i SHALL be k+1 when the youngest matching slot k has rem=0. In all other cases, including no match and rem>0, it SHALL be 0.
REQ-025 MDU counter (4b): on accept (d_valid, d_mdu_start, no stall, no flush) it SHALL load DIV_LAT if d_mdu_div=1, else MULT_LAT. Otherwise it SHALL decrement, saturating at 0.
REQ-026 MDU stall SHALL be asserted when d_valid=1, d_mdu_req=1 and the counter is nonzero.
REQ-027 stall SHALL be the OR of the source-1 stall, the source-2 stall and the MDU stall. stall, fwd_sel and mdu_busy SHALL be purely combinational from the slots, the counter and the D inputs.
REQ-028 flush SHALL clear all slots to a3=0, rem=0 on the next edge. It SHALL not change the MDU counter. stall SHALL still be evaluated during the flush cycle.
REQ-029 Register 0 SHALL never cause a stall or a nonzero fwd_sel.

Reset
REQ-030 On reset=1 at an edge, all slots SHALL become a3=0, rem=0 and the counter SHALL become 0. Reset SHALL take priority over flush and accept.
REQ-031 After reset, with all D inputs at 0: stall=0, fwd_sel1=fwd_sel2=0, mdu_busy=0.
REQ-032 Reset asserted mid-MDU-operation SHALL clear mdu_busy on the next edge.

Verification (NSTAGE=3, MULT_LAT=5, DIV_LAT=10)
REQ-033 lw $2 (tnew=3), then add with a1=$2, tuse1=1 -> stall=1 for 1 cycle, then stall=0 and fwd_sel1=0 (slot 1, rem=1).
REQ-034 ori $3 (tnew=2), then beq with a1=$3, tuse1=0 -> stall=1 for 1 cycle, then stall=0 and fwd_sel1=2.
REQ-035 jal ($31, tnew=1), then jr with a1=$31, tuse1=0 -> stall=0 and fwd_sel1=1 in the same cycle.
REQ-036 ori $4 in slot 1 (rem=0) and addu $4 in slot 0 (rem=1); D sub with a2=$4, tuse2=1 -> stall=0, fwd_sel2=0 (youngest slot wins). Repeat with a2=$0 -> stall=0, fwd_sel2=0.
REQ-037 mult accepted, then mflo (d_mdu_req=1) -> stall=1 for exactly 5 cycles. div then mfhi -> stall for 10 cycles. Reset at div cycle 4 -> mdu_busy=0 and stall=0 after the edge.
REQ-038 lw $5 in slot 0, flush=1 for one cycle -> next cycle all slots empty. D using $5 with tuse=0 -> stall=0, fwd_sel=0. mdu_busy is unchanged by the flush.

Source files
------------

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - D-stage hazard detection, forwarding select and MDU busy tracking
// Tracks destination/ready-time of NSTAGE in-flight slots behind D.
module hazard_tracker #(
    parameter int NSTAGE   = 3,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_a1,
    input  logic [4:0] d_a2,
    input  logic [1:0] d_tuse1,
    input  logic [1:0] d_tuse2,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
    input  logic       d_mdu_req,
    input  logic       d_mdu_start,
    input  logic       d_mdu_div,
    input  logic       flush,
    output logic       stall,
    output logic [2:0] fwd_sel1,
    output logic [2:0] fwd_sel2,
    output logic       mdu_busy
);

    logic [4:0] r_a3  [NSTAGE];
    logic [1:0] r_rem [NSTAGE];
    logic [3:0] r_mdu_cnt;

    logic       w_hit1, w_hit2;
    logic [2:0] w_idx1, w_idx2;
    logic [1:0] w_rem1, w_rem2;
    logic       w_stall1, w_stall2, w_mdu_stall;
    logic       w_accept;
    logic [1:0] w_rem_new;

    // Scan oldest to youngest so the lowest-index match overwrites older ones.
    always_comb begin
        w_hit1 = 1'b0;
        w_idx1 = 3'd0;
        w_rem1 = 2'd0;
        w_hit2 = 1'b0;
        w_idx2 = 3'd0;
        w_rem2 = 2'd0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (d_a1 != 5'd0 && r_a3[k] == d_a1) begin
                w_hit1 = 1'b1;
                w_idx1 = 3'(k);
                w_rem1 = r_rem[k];
            end
            if (d_a2 != 5'd0 && r_a3[k] == d_a2) begin
                w_hit2 = 1'b1;
                w_idx2 = 3'(k);
                w_rem2 = r_rem[k];
            end
        end
    end

    assign w_stall1    = d_valid && w_hit1 && (w_rem1 > d_tuse1);
    assign w_stall2    = d_valid && w_hit2 && (w_rem2 > d_tuse2);
    assign w_mdu_stall = d_valid && d_mdu_req && (r_mdu_cnt != 4'd0);
    assign stall       = w_stall1 || w_stall2 || w_mdu_stall;
    assign fwd_sel1    = (w_hit1 && w_rem1 == 2'd0) ? w_idx1 + 3'd1 : 3'd0;
    assign fwd_sel2    = (w_hit2 && w_rem2 == 2'd0) ? w_idx2 + 3'd1 : 3'd0;
    assign mdu_busy    = (r_mdu_cnt != 4'd0);

    assign w_accept  = d_valid && !stall && !flush;
    assign w_rem_new = (d_tnew == 2'd0) ? 2'd0 : d_tnew - 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                r_a3[k]  <= 5'd0;
                r_rem[k] <= 2'd0;
            end
            r_mdu_cnt <= 4'd0;
        end else begin
            if (flush) begin
                for (int k = 0; k < NSTAGE; k++) begin
                    r_a3[k]  <= 5'd0;
                    r_rem[k] <= 2'd0;
                end
            end else begin
                r_a3[0]  <= w_accept ? d_a3 : 5'd0;
                r_rem[0] <= w_accept ? w_rem_new : 2'd0;
                for (int k = 1; k < NSTAGE; k++) begin
                    r_a3[k]  <= r_a3[k-1];
                    r_rem[k] <= (r_rem[k-1] == 2'd0) ? 2'd0 : r_rem[k-1] - 2'd1;
                end
            end
            // The counter keeps running through a flush.
            if (w_accept && d_mdu_start)
                r_mdu_cnt <= d_mdu_div ? 4'(DIV_LAT) : 4'(MULT_LAT);
            else if (r_mdu_cnt != 4'd0)
                r_mdu_cnt <= r_mdu_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - directed bench for hazard_tracker
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_a1, d_a2, d_a3;
    logic [1:0] d_tuse1, d_tuse2, d_tnew;
    logic       d_mdu_req, d_mdu_start, d_mdu_div;
    logic       flush;
    logic       stall;
    logic [2:0] fwd_sel1, fwd_sel2;
    logic       mdu_busy;

    int passed = 0;
    int total  = 0;
    int n;

    hazard_tracker #(.NSTAGE(3), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid),
        .d_a1(d_a1), .d_a2(d_a2), .d_tuse1(d_tuse1), .d_tuse2(d_tuse2),
        .d_a3(d_a3), .d_tnew(d_tnew),
        .d_mdu_req(d_mdu_req), .d_mdu_start(d_mdu_start), .d_mdu_div(d_mdu_div),
        .flush(flush), .stall(stall), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [4:0] a1, input logic [1:0] t1,
                         input logic [4:0] a2, input logic [1:0] t2,
                         input logic [4:0] a3, input logic [1:0] tn,
                         input logic req, input logic start, input logic dv);
        d_valid = v; d_a1 = a1; d_tuse1 = t1; d_a2 = a2; d_tuse2 = t2;
        d_a3 = a3; d_tnew = tn; d_mdu_req = req; d_mdu_start = start; d_mdu_div = dv;
        #1;
    endtask

    task automatic bubble(input int cycles);
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Counts consecutive stall cycles with D held; bounded so a stuck stall still ends.
    task automatic count_stall(output int cnt);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (stall !== 1'b1) break;
            cnt++;
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_fwd1", fwd_sel1, 0);
        chk("rst_fwd2", fwd_sel2, 0);
        chk("rst_busy", mdu_busy, 0);

        // lw $2 then add using $2 at tuse=1
        set_d(1, 0, 0, 0, 0, 2, 3, 0, 0, 0); tick();
        set_d(1, 2, 1, 0, 0, 6, 2, 0, 0, 0);
        chk("lw_add_stall", stall, 1);
        tick();
        chk("lw_add_release", stall, 0);
        chk("lw_add_fwd", fwd_sel1, 0);
        bubble(4);

        // ori $3 then beq
        set_d(1, 0, 0, 0, 0, 3, 2, 0, 0, 0); tick();
        set_d(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ori_beq_stall", stall, 1);
        tick();
        chk("ori_beq_release", stall, 0);
        chk("ori_beq_fwd", fwd_sel1, 2);
        bubble(4);

        // jal then jr, also forwarding from the oldest slot and past it
        set_d(1, 0, 0, 0, 0, 31, 1, 0, 0, 0); tick();
        set_d(1, 31, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("jal_jr_stall", stall, 0);
        chk("jal_jr_fwd", fwd_sel1, 1);
        bubble(2);
        set_d(1, 31, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("jal_slot2_fwd", fwd_sel1, 3);
        bubble(1);
        set_d(1, 31, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("jal_dropped_fwd", fwd_sel1, 0);
        bubble(4);

        // ori $4 then addu $4: youngest slot wins
        set_d(1, 0, 0, 0, 0, 4, 2, 0, 0, 0); tick();
        set_d(1, 0, 0, 0, 0, 4, 2, 0, 0, 0); tick();
        set_d(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
        chk("young_stall", stall, 0);
        chk("young_fwd2", fwd_sel2, 0);
        set_d(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("young_tuse0_stall", stall, 1);
        set_d(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_stall", stall, 0);
        chk("r0_fwd2", fwd_sel2, 0);
        set_d(0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bubble_no_stall", stall, 0);
        bubble(4);

        // mult then mflo
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 1, 0); tick();
        chk("mult_busy", mdu_busy, 1);
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        count_stall(n);
        chk("mult_stall_cycles", n, 5);
        tick();
        bubble(1);

        // div then mfhi
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 1, 1); tick();
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        count_stall(n);
        chk("div_stall_cycles", n, 10);
        tick();
        bubble(1);

        // reset mid-div
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 1, 1); tick();
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick(); tick(); tick();
        chk("div_mid_busy", mdu_busy, 1);
        chk("div_mid_stall", stall, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("div_rst_busy", mdu_busy, 0);
        chk("div_rst_stall", stall, 0);
        bubble(2);

        // flush with an MDU op in flight
        set_d(1, 0, 0, 0, 0, 0, 0, 1, 1, 0); tick();
        set_d(1, 0, 0, 0, 0, 5, 3, 0, 0, 0); tick();
        set_d(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        #1;
        chk("flush_cycle_stall", stall, 1);
        tick();
        flush = 1'b0;
        #1;
        chk("post_flush_stall", stall, 0);
        chk("post_flush_fwd1", fwd_sel1, 0);
        chk("post_flush_busy", mdu_busy, 1);
        set_d(1, 5, 0, 0, 0, 0, 0, 1, 0, 0);
        count_stall(n);
        chk("post_flush_mdu_cycles", n, 3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
